// File: rtl/pipe_enq_arbiter.sv
// Round-robin arbiter that funnels NREQ one-entry holding slots into a small FIFO feeding pipe_enq.
// Optional counters stat_sent / stat_stall are built when PIPE_ARB_STATS_EN is defined.
module pipe_enq_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 128,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NREQ-1:0]            req_enq__ENA,
    input  logic [NREQ*DATA_WIDTH-1:0] req_enq_v,
    output logic [NREQ-1:0]            req_enq__RDY,
    output logic                       pipe_enq__ENA,
    output logic [DATA_WIDTH-1:0]      pipe_enq_v,
`ifdef PIPE_ARB_STATS_EN
    output logic [31:0]                stat_sent,
    output logic [31:0]                stat_stall,
`endif
    input  logic                       pipe_enq__RDY
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [NREQ-1:0]       slot_full_q, slot_full_d;
    logic [DATA_WIDTH-1:0] slot_data_q [NREQ];
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;

    logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic                  grant_vld;
    logic [PW-1:0]         grant_idx;
    logic [PW-1:0]         cand;
    logic                  fifo_nonempty;
    logic                  push;
    logic                  pop;

    assign fifo_nonempty = (count_q != '0);
    assign push          = grant_vld;
    assign pop           = pipe_enq__ENA;

    assign req_enq__RDY  = ~slot_full_q;
    assign pipe_enq__ENA = fifo_nonempty & pipe_enq__RDY;
    assign pipe_enq_v    = fifo_nonempty ? fifo_mem_q[rd_ptr_q] : '0;

    // Descending scan so the last hit is the first full slot after rr_ptr_q.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr_q;
        cand      = '0;
        if (count_q < DEPTH_C) begin
            for (int k = NREQ; k >= 1; k--) begin
                cand = PW'((int'(rr_ptr_q) + k) % NREQ);
                if (slot_full_q[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    // Capture only into empty slots, drain only full ones: the two never collide.
    always_comb begin
        slot_full_d = slot_full_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!slot_full_q[i] && req_enq__ENA[i]) begin
                slot_full_d[i] = 1'b1;
            end
        end
        if (grant_vld) begin
            slot_full_d[grant_idx] = 1'b0;
        end
    end

    always_comb begin
        rr_ptr_d = grant_vld ? grant_idx : rr_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            slot_full_q <= '0;
            rr_ptr_q    <= PTR_RST;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            slot_full_q <= slot_full_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Payload storage carries no reset; validity lives in slot_full_q / count_q.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NREQ; i++) begin
            if (!slot_full_q[i] && req_enq__ENA[i]) begin
                slot_data_q[i] <= req_enq_v[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= slot_data_q[grant_idx];
        end
    end

`ifdef PIPE_ARB_STATS_EN
    logic [31:0] sent_q, sent_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        sent_d  = pop ? sent_q + 32'd1 : sent_q;
        stall_d = stall_q;
        if (fifo_nonempty && !pipe_enq__RDY && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sent_q  <= '0;
            stall_q <= '0;
        end else begin
            sent_q  <= sent_d;
            stall_q <= stall_d;
        end
    end

    assign stat_sent  = sent_q;
    assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_pipe_enq_arbiter.sv
// Self-checking bench for pipe_enq_arbiter: queue-based reference model plus directed literal checks.
module tb_pipe_enq_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 128;
    localparam int DEPTH = 2;

    logic                 CLK = 1'b0;
    logic                 nRST;
    logic [NREQ-1:0]      ena;
    logic [NREQ*DW-1:0]   vbus;
    logic [NREQ-1:0]      rdy;
    logic                 pena;
    logic [DW-1:0]        pv;
    logic                 prdy;
`ifdef PIPE_ARB_STATS_EN
    logic [31:0]          st_sent;
    logic [31:0]          st_stall;
    logic [31:0]          m_sent;
    logic [31:0]          m_stall;
`endif

    always #5 CLK = ~CLK;

    pipe_enq_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .req_enq__ENA  (ena),
        .req_enq_v     (vbus),
        .req_enq__RDY  (rdy),
        .pipe_enq__ENA (pena),
        .pipe_enq_v    (pv),
`ifdef PIPE_ARB_STATS_EN
        .stat_sent     (st_sent),
        .stat_stall    (st_stall),
`endif
        .pipe_enq__RDY (prdy)
    );

    // Reference model: slot occupancy, FIFO as a queue, round-robin pointer.
    bit          m_full [NREQ];
    logic [DW-1:0] m_word [NREQ];
    logic [DW-1:0] m_fifo [$];
    int          m_ptr;
    int          issue_seq [NREQ];
    int          exp_seq [NREQ];
    logic [7:0]  out_ids [$];
    logic [DW-1:0] out_words [$];
    int          passed = 0;
    int          total  = 0;
    int          ena_cycles;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [NREQ-1:0] m_free();
        logic [NREQ-1:0] r;
        for (int i = 0; i < NREQ; i++) r[i] = !m_full[i];
        return r;
    endfunction

    function automatic int m_held();
        int n;
        n = m_fifo.size();
        for (int i = 0; i < NREQ; i++) n += m_full[i] ? 1 : 0;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) begin
            m_full[i]  = 1'b0;
            exp_seq[i] = issue_seq[i];
        end
        m_fifo.delete();
        m_ptr = NREQ - 1;
`ifdef PIPE_ARB_STATS_EN
        m_sent  = 0;
        m_stall = 0;
`endif
    endtask

    task automatic model_update();
        bit            old_full [NREQ];
        int            g;
        bit            pop;
        logic [DW-1:0] w;
        if (!nRST) begin
            model_reset();
            return;
        end
        old_full = m_full;
        pop = (m_fifo.size() != 0) && prdy;
`ifdef PIPE_ARB_STATS_EN
        if (pop) m_sent = m_sent + 1;
        if (m_fifo.size() != 0 && !prdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
`endif
        g = -1;
        if (m_fifo.size() < DEPTH) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (g < 0 && old_full[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (g >= 0) begin
            m_fifo.push_back(m_word[g]);
            m_full[g] = 1'b0;
            m_ptr = g;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (ena[i] && !old_full[i]) begin
                w = vbus[i*DW +: DW];
                m_full[i] = 1'b1;
                m_word[i] = w;
                if (w[119:112] == 8'hA5) issue_seq[i]++;
            end
        end
    endtask

    task automatic compare();
        logic [7:0] id;
        chk("req_rdy", rdy, m_free());
        chk("pipe_ena", pena, ((m_fifo.size() != 0) && prdy) ? 1'b1 : 1'b0);
        chk("pipe_v", pv, (m_fifo.size() != 0) ? m_fifo[0] : '0);
`ifdef PIPE_ARB_STATS_EN
        chk("stat_sent", st_sent, m_sent);
        chk("stat_stall", st_stall, m_stall);
`endif
        if (pena === 1'b1) begin
            ena_cycles++;
            id = pv[127:120];
            out_ids.push_back(id);
            out_words.push_back(pv);
            if (pv[119:112] == 8'hA5) begin
                if (id < NREQ) begin
                    chk("seq_order", pv[31:0], 32'(exp_seq[id]));
                    exp_seq[id]++;
                end else begin
                    chk("req_id_range", id, 0);
                end
            end
        end
    endtask

    task automatic tick();
        #1;
        compare();
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    task automatic drive(input logic [NREQ-1:0] mask);
        logic [DW-1:0] w;
        for (int i = 0; i < NREQ; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            w[127:120] = 8'(i);
            w[119:112] = 8'hA5;
            w[31:0]    = 32'(issue_seq[i]);
            vbus[i*DW +: DW] = w;
        end
        ena = mask;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        ena  = '0;
        model_reset();
        tick();
        nRST = 1'b1;
    endtask

    initial begin
        int base;
        logic [DW-1:0] word_a;
        logic [DW-1:0] word_b;
        nRST = 1'b0;
        ena  = '0;
        vbus = '0;
        prdy = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            issue_seq[i] = 0;
            m_word[i]    = '0;
        end
        model_reset();
        @(negedge CLK);
        tick();
        tick();
        nRST = 1'b1;

        // Reset while loaded
        prdy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(m_free());
            tick();
        end
        chk("preload_held", m_held(), DEPTH + NREQ);
        nRST = 1'b0;
        prdy = 1'b1;
        ena  = '0;
        model_reset();
        #1;
        chk("rst_rdy", rdy, 4'b1111);
        chk("rst_ena", pena, 1'b0);
        chk("rst_v", pv, '0);
        tick();
        tick();
        nRST = 1'b1;
        base = out_words.size();
        for (int c = 0; c < 6; c++) tick();
        chk("rst_no_word", out_words.size() - base, 0);

        // Single word latency
        vbus = '0;
        vbus[0 +: DW] = 128'h1234;
        ena = 4'b0001;
        tick();
        ena = '0;
        #1;
        chk("single_rdy_t1", rdy[0], 1'b0);
        chk("single_ena_t1", pena, 1'b0);
        tick();
        #1;
        chk("single_rdy_t2", rdy[0], 1'b1);
        chk("single_ena_t2", pena, 1'b1);
        chk("single_v_t2", pv, 128'h1234);
        tick();
        #1;
        chk("single_ena_t3", pena, 1'b0);
        tick();

        // Fairness with all requesters saturating
        do_reset();
        base = out_ids.size();
        ena_cycles = 0;
        for (int c = 0; c < 40; c++) begin
            drive(m_free());
            tick();
        end
        for (int k = 0; k < 16; k++) chk("fair_order", out_ids[base + k], 8'(k % NREQ));
        chk("fair_throughput", ena_cycles, 38);
        ena = '0;
        for (int c = 0; c < 8; c++) tick();

        // Backpressure
        prdy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive(m_free());
            tick();
        end
        ena = '0;
        #1;
        chk("bp_held", m_held(), 6);
        chk("bp_rdy", rdy, 4'b0000);
        prdy = 1'b1;
        base = out_words.size();
        for (int c = 0; c < 12; c++) tick();
        chk("bp_drained", out_words.size() - base, 6);
        chk("bp_empty", m_held(), 0);

        // Only requesters 1 and 3 active
        do_reset();
        base = out_ids.size();
        ena_cycles = 0;
        for (int c = 0; c < 30; c++) begin
            drive(m_free() & 4'b1010);
            tick();
        end
        for (int k = 0; k < 12; k++) chk("skip_order", out_ids[base + k], (k % 2 == 0) ? 8'd1 : 8'd3);
        chk("skip_throughput", ena_cycles, 28);
        ena = '0;
        for (int c = 0; c < 6; c++) tick();

        // ENA while not ready must not overwrite the held word
        do_reset();
        prdy = 1'b0;
        drive(4'b0011);
        tick();
        ena = '0;
        tick();
        tick();
        word_a = {8'd2, 8'h00, 112'hAAAA_0000_1111_2222_3333_4444_5555};
        word_b = {8'd2, 8'h00, 112'hBBBB_9999_8888_7777_6666_5555_4444};
        vbus[2*DW +: DW] = word_a;
        ena = 4'b0100;
        tick();
        vbus[2*DW +: DW] = word_b;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("proto_rdy2", rdy[2], 1'b0);
            tick();
        end
        ena  = '0;
        prdy = 1'b1;
        base = out_words.size();
        for (int c = 0; c < 6; c++) tick();
        chk("proto_count", out_words.size() - base, 3);
        chk("proto_word", out_words[base + 2], word_a);

        // Randomized traffic with one mid-run reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            drive(4'($urandom_range(0, 15)));
            if (c < 1000) prdy = ($urandom_range(0, 3) != 0);
            else if (c < 2000) prdy = ($urandom_range(0, 3) == 0);
            else prdy = $urandom_range(0, 1) == 1;
            if (c == 1500) begin
                nRST = 1'b0;
                model_reset();
            end
            if (c == 1502) nRST = 1'b1;
            tick();
        end
        ena  = '0;
        prdy = 1'b1;
        for (int c = 0; c < 12; c++) tick();
        chk("final_empty", m_held(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
